param_updown_counter: RTL and testbench

Parametrised up/down counter with a programmable modulo limit, parallel load, selectable wrap or saturate mode, and sticky overflow/underflow flags. It is the general-purpose successor to the fixed 4-bit up-counter. Timer, prescaler and event-count logic instantiate it directly. All state is registered on one clock with an asynchronous active-high reset.

---
 rtl/param_updown_counter.sv | 99 +++++++++
 tb/tb_param_updown_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with a programmable terminal count, parallel load,
// wrap or saturate boundary handling, and sticky overflow/underflow flags.
module param_updown_counter #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     MAX_VALUE = {WIDTH{1'b1}},
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] counter_out,
    output logic             overflow_out,
    output logic             underflow_out,
    output logic             wrap_pulse,
    output logic             terminal_out
);

    // One extra bit keeps the load clamp compare meaningful when MAX_VALUE is all ones.
    localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX_VALUE};
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] UP_EDGE  = SATURATE ? MAX_VALUE : ZERO;
    localparam logic [WIDTH-1:0] DN_EDGE  = SATURATE ? ZERO : MAX_VALUE;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;
    logic             ovf_set, udf_set;

    assign at_max  = (cnt_q == MAX_VALUE);
    assign at_zero = (cnt_q == ZERO);

    // Next-state: load beats stepping; flag set beats flag clear.
    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;

        if (load) begin
            if ({1'b0, load_value} > MAX_EXT) begin
                cnt_d = MAX_VALUE;
            end else begin
                cnt_d = load_value;
            end
        end else if (enable) begin
            if (up_down) begin
                if (at_max) begin
                    cnt_d   = UP_EDGE;
                    ovf_set = 1'b1;
                    wrap_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    cnt_d   = DN_EDGE;
                    udf_set = 1'b1;
                    wrap_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end

        ovf_d = ovf_set | (ovf_q & ~clear_flags);
        udf_d = udf_set | (udf_q & ~clear_flags);
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            wrap_q <= wrap_d;
        end
    end

    assign counter_out   = cnt_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = udf_q;
    assign wrap_pulse    = wrap_q;

    // Terminal count seen in the current direction, zero latency.
    assign terminal_out = (up_down & at_max) | (~up_down & at_zero);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: one wrapping and one saturating counter, WIDTH=4, MAX_VALUE=9,
// driven by shared stimulus and checked against hand-computed values.
module tb_param_updown_counter;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         up_down = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         clear_flags = 1'b0;

    logic [W-1:0] w_cnt, s_cnt;
    logic         w_ovf, w_udf, w_wrap, w_term;
    logic         s_ovf, s_udf, s_wrap, s_term;

    int n_vec = 0;
    int n_err = 0;

    param_updown_counter #(.WIDTH(W), .MAX_VALUE(4'd9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear_flags(clear_flags), .counter_out(w_cnt),
        .overflow_out(w_ovf), .underflow_out(w_udf), .wrap_pulse(w_wrap),
        .terminal_out(w_term)
    );

    param_updown_counter #(.WIDTH(W), .MAX_VALUE(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear_flags(clear_flags), .counter_out(s_cnt),
        .overflow_out(s_ovf), .underflow_out(s_udf), .wrap_pulse(s_wrap),
        .terminal_out(s_term)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every vector, reports miscompares.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit term_model(input logic [W-1:0] cnt, input logic dir);
        return (dir && cnt == 4'd9) || (!dir && cnt == 4'd0);
    endfunction

    task automatic expect_w(input string tag, input logic [W-1:0] cnt,
                            input bit ovf, input bit udf, input bit wrp);
        check({tag, ".w.cnt"},  32'(w_cnt),  32'(cnt));
        check({tag, ".w.ovf"},  32'(w_ovf),  32'(ovf));
        check({tag, ".w.udf"},  32'(w_udf),  32'(udf));
        check({tag, ".w.wrap"}, 32'(w_wrap), 32'(wrp));
        check({tag, ".w.term"}, 32'(w_term), 32'(term_model(cnt, up_down)));
    endtask

    task automatic expect_s(input string tag, input logic [W-1:0] cnt,
                            input bit ovf, input bit udf, input bit wrp);
        check({tag, ".s.cnt"},  32'(s_cnt),  32'(cnt));
        check({tag, ".s.ovf"},  32'(s_ovf),  32'(ovf));
        check({tag, ".s.udf"},  32'(s_udf),  32'(udf));
        check({tag, ".s.wrap"}, 32'(s_wrap), 32'(wrp));
        check({tag, ".s.term"}, 32'(s_term), 32'(term_model(cnt, up_down)));
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        expect_w("reset", 4'd0, 0, 0, 0);
        expect_s("reset", 4'd0, 0, 0, 0);
        reset = 1'b0;

        // Count up 12 cycles: wrap goes 1..9,0,1,2; saturate pins at 9
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            expect_w($sformatf("up%0d", i), 4'(i % 10), i >= 10, 0, i == 10);
            expect_s($sformatf("up%0d", i), (i <= 9) ? 4'(i) : 4'd9, i >= 10, 0, i >= 10);
        end

        // Load 9, then clear_flags together with an up-step at 9: set wins
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd9;
        step();
        expect_w("ld9", 4'd9, 1, 0, 0);
        expect_s("ld9", 4'd9, 1, 0, 0);
        load        = 1'b0;
        enable      = 1'b1;
        clear_flags = 1'b1;
        step();
        expect_w("clr_set", 4'd0, 1, 0, 1);
        expect_s("clr_set", 4'd9, 1, 0, 1);
        enable = 1'b0;
        step();
        expect_w("clr_only", 4'd0, 0, 0, 0);
        expect_s("clr_only", 4'd9, 0, 0, 0);
        clear_flags = 1'b0;

        // Load 5, load 0, then two down-steps
        load       = 1'b1;
        load_value = 4'd5;
        step();
        expect_w("ld5", 4'd5, 0, 0, 0);
        expect_s("ld5", 4'd5, 0, 0, 0);
        load_value = 4'd0;
        step();
        up_down = 1'b0;
        #1;
        expect_w("ld0", 4'd0, 0, 0, 0);
        expect_s("ld0", 4'd0, 0, 0, 0);
        load   = 1'b0;
        enable = 1'b1;
        step();
        expect_w("dn1", 4'd9, 0, 1, 1);
        expect_s("dn1", 4'd0, 0, 1, 1);
        step();
        expect_w("dn2", 4'd8, 0, 1, 0);
        expect_s("dn2", 4'd0, 0, 1, 1);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        expect_w("idle", 4'd8, 0, 1, 0);
        expect_s("idle", 4'd0, 0, 1, 0);

        // Saturate from 8: 9, 9, 9 with pulses on edges 2 and 3
        load       = 1'b1;
        load_value = 4'd8;
        up_down    = 1'b1;
        step();
        load   = 1'b0;
        enable = 1'b1;
        step();
        expect_w("sat1", 4'd9, 0, 1, 0);
        expect_s("sat1", 4'd9, 0, 1, 0);
        step();
        expect_w("sat2", 4'd0, 1, 1, 1);
        expect_s("sat2", 4'd9, 1, 1, 1);
        step();
        expect_w("sat3", 4'd1, 1, 1, 0);
        expect_s("sat3", 4'd9, 1, 1, 1);

        // Clear everything, then out-of-range load with enable: clamps, no flags
        enable      = 1'b0;
        clear_flags = 1'b1;
        step();
        expect_w("clr_all", 4'd1, 0, 0, 0);
        expect_s("clr_all", 4'd9, 0, 0, 0);
        clear_flags = 1'b0;
        load        = 1'b1;
        load_value  = 4'd15;
        enable      = 1'b1;
        step();
        expect_w("ld15", 4'd9, 0, 0, 0);
        expect_s("ld15", 4'd9, 0, 0, 0);

        // Set flags, load 7, then async reset between edges
        load = 1'b0;
        step();
        expect_w("pre_up", 4'd0, 1, 0, 1);
        expect_s("pre_up", 4'd9, 1, 0, 1);
        up_down = 1'b0;
        step();
        expect_w("pre_dn", 4'd9, 1, 1, 1);
        expect_s("pre_dn", 4'd8, 1, 0, 0);
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd7;
        step();
        expect_w("ld7", 4'd7, 1, 1, 0);
        expect_s("ld7", 4'd7, 1, 0, 0);
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        expect_w("async_rst", 4'd0, 0, 0, 0);
        expect_s("async_rst", 4'd0, 0, 0, 0);
        step();
        step();
        expect_w("rst_hold", 4'd0, 0, 0, 0);
        expect_s("rst_hold", 4'd0, 0, 0, 0);
        reset = 1'b0;
        step();
        expect_w("resume1", 4'd1, 0, 0, 0);
        expect_s("resume1", 4'd1, 0, 0, 0);
        step();
        expect_w("resume2", 4'd2, 0, 0, 0);
        expect_s("resume2", 4'd2, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
